// File: rtl/preg_freelist.sv
// preg_freelist: circular free list of physical register ids for a 2-wide
// rename stage.
//
// Three pointers index a FREE_NUM-entry buffer. Each pointer carries an
// index plus a wrap bit:
//   spec_head - next entry handed out to rename (speculative)
//   arch_head - committed head; a flush rewinds spec_head to it
//   tail      - next slot written by a retire releasing its old mapping
//
// Ports:
//   clk, resetn                 - clock, synchronous active-low reset
//   alloc_req[1:0]              - per-slot allocation request
//   alloc_ready                 - enough free entries for every set request bit
//   alloc_preg0/1               - ids granted to slot 0 / slot 1 (combinational)
//   retire_valid[1:0]           - per-slot retire that frees an old mapping
//   retire_old_preg0/1          - old mapping released by that retire
//   flush                       - squash all speculative allocations
//   free_count                  - speculative free entries (0..FREE_NUM)
//   overflow_err                - sticky flag: a retire released more than was allocated
//
// Only MACHINE_WIDTH = 2 is supported.
module preg_freelist #(
    parameter int MACHINE_WIDTH = 2,
    parameter int PREG_NUM      = 64,
    parameter int FREE_NUM      = PREG_NUM - 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [MACHINE_WIDTH-1:0]      alloc_req,
    output logic                          alloc_ready,
    output logic [$clog2(PREG_NUM)-1:0]   alloc_preg0,
    output logic [$clog2(PREG_NUM)-1:0]   alloc_preg1,
    input  logic [MACHINE_WIDTH-1:0]      retire_valid,
    input  logic [$clog2(PREG_NUM)-1:0]   retire_old_preg0,
    input  logic [$clog2(PREG_NUM)-1:0]   retire_old_preg1,
    input  logic                          flush,
    output logic [$clog2(FREE_NUM):0]     free_count,
    output logic                          overflow_err
);

    localparam int PW   = $clog2(PREG_NUM);
    localparam int IW   = $clog2(FREE_NUM);
    localparam int PTRW = IW + 1;

    logic [PW-1:0]   fl_q [FREE_NUM];
    logic [PW-1:0]   fl_d [FREE_NUM];
    logic [PTRW-1:0] spec_head_q, spec_head_d;
    logic [PTRW-1:0] arch_head_q, arch_head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic            ovf_q, ovf_d;

    logic [1:0]      n_req, n_ret, n_acc;
    logic [PTRW-1:0] fc, room;
    logic [IW-1:0]   sh_idx, sh_idx_p1, tail_idx, tail_idx_p1;
    logic            ovf_hit;
    logic [PW-1:0]   first_old;

    // Allocation side: all-or-nothing grant, slots served in index order.
    always_comb begin
        n_req       = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
        fc          = tail_q - spec_head_q;
        alloc_ready = (fc >= PTRW'(n_req));
        sh_idx      = spec_head_q[IW-1:0];
        sh_idx_p1   = sh_idx + IW'(1);
        alloc_preg0 = fl_q[sh_idx];
        // Slot 1 takes the head entry unless slot 0 already claimed it.
        alloc_preg1 = alloc_req[0] ? fl_q[sh_idx_p1] : fl_q[sh_idx];
        free_count  = fc;
    end

    // Retire side. Entries between spec_head and tail are free, so
    // FREE_NUM - fc is the number of ids currently handed out. Releasing more
    // than that would overrun the buffer: the excess is dropped and the
    // sticky error raised. tail and arch_head advance by the accepted count
    // only, which keeps arch_head from overtaking spec_head.
    always_comb begin
        n_ret       = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]};
        room        = PTRW'(FREE_NUM) - fc;
        ovf_hit     = (PTRW'(n_ret) > room);
        n_acc       = ovf_hit ? room[1:0] : n_ret;
        first_old   = retire_valid[0] ? retire_old_preg0 : retire_old_preg1;
        tail_idx    = tail_q[IW-1:0];
        tail_idx_p1 = tail_idx + IW'(1);

        fl_d = fl_q;
        if (n_acc != 2'd0) begin
            fl_d[tail_idx] = first_old;
        end
        if (n_acc == 2'd2) begin
            fl_d[tail_idx_p1] = retire_old_preg1;
        end

        tail_d      = tail_q + PTRW'(n_acc);
        arch_head_d = arch_head_q + PTRW'(n_acc);
        ovf_d       = ovf_q | ovf_hit;

        // Flush rewinds to the committed head including this cycle's retires,
        // and wins over any allocation request in the same cycle.
        if (flush) begin
            spec_head_d = arch_head_d;
        end else if (alloc_ready) begin
            spec_head_d = spec_head_q + PTRW'(n_req);
        end else begin
            spec_head_d = spec_head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < FREE_NUM; i++) begin
                fl_q[i] <= PW'(PREG_NUM - FREE_NUM + i);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= PTRW'(FREE_NUM);
            ovf_q       <= 1'b0;
        end else begin
            fl_q        <= fl_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            ovf_q       <= ovf_d;
        end
    end

    assign overflow_err = ovf_q;

endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL have parameter MACHINE_WIDTH, default 2: allocation/retire slots per cycle; only 2 is supported.
REQ-002 SHALL have parameter PREG_NUM, default 64: physical registers; preg id width is 6 bits.
REQ-003 SHALL have parameter FREE_NUM, default 32 (PREG_NUM-32): free-list depth.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port alloc_req, input, 2 bits: per-slot destination-preg request from renaming.
REQ-008 SHALL have port alloc_ready, output, 1 bit: enough free pregs for all set alloc_req bits this cycle.
REQ-009 SHALL have ports alloc_preg0 and alloc_preg1, output, 6 bits each: preg granted to slot 0 and slot 1.
REQ-010 SHALL have port retire_valid, input, 2 bits: per-slot retire of an instruction that has a destination.
REQ-011 SHALL have ports retire_old_preg0 and retire_old_preg1, input, 6 bits each: the previous mapping freed by that retire.
REQ-012 SHALL have port flush, input, 1 bit: mispredict/exception squash of all speculative allocations.
REQ-013 SHALL have port free_count, output, 6 bits: speculative free entries, range 0..32.
REQ-014 SHALL have port overflow_err, output, 1 bit: sticky illegal-release flag.

Function
REQ-015 SHALL store free preg ids in a 32-entry circular buffer with 6-bit pointers (5-bit index plus wrap bit): spec_head, arch_head, tail.
REQ-016 SHALL compute free_count = tail - spec_head modulo 64; full when free_count=32; empty when 0.
REQ-017 SHALL compute n_req = popcount(alloc_req), and SHALL set alloc_ready = (free_count >= n_req) combinationally.
REQ-018 SHALL be all-or-nothing: when alloc_ready=0, no entry is consumed and spec_head is held.
REQ-019 SHALL grant in order: the lowest-indexed requesting slot gets buf[spec_head] and the next gets buf[spec_head+1].
REQ-020 SHALL treat alloc_req=2'b10 as slot 1 receiving buf[spec_head].
REQ-021 SHALL drive alloc_preg outputs combinationally; they are don't-care for non-requesting slots or when alloc_ready=0.
REQ-022 SHALL advance spec_head by n_req on a rising edge with alloc_ready=1, flush=0.
REQ-023 SHALL write retiring old pregs at tail in slot order; slot 1 alone writes buf[tail].
REQ-024 SHALL advance tail by popcount(retire_valid).
REQ-025 SHALL advance arch_head by popcount(retire_valid), since each retire commits one allocation.
REQ-026 SHALL NOT bypass released entries: they are allocatable from the next cycle only.
REQ-027 SHALL set, on flush, spec_head := arch_head after that cycle's retire increment, and SHALL ignore alloc_req that cycle; flush has priority over allocation.
REQ-028 SHALL process retire normally during a flush cycle.
REQ-029 SHALL set overflow_err and drop the excess writes if a retire would make tail - arch_head exceed 32.
REQ-030 SHALL treat alloc and retire in the same cycle as independent: pointers update concurrently and wrap at 64.

Reset
REQ-031 SHALL, on resetn=0 at a clock edge, load buf[i]=32+i for i=0..31, set spec_head=arch_head=0 and tail=32 (wrap bit set, index 0), and clear overflow_err.
REQ-032 SHALL have free_count=32 and alloc_ready=1 after reset.
REQ-033 SHALL let reset override flush, alloc and retire; reset mid-operation discards all speculative state.

Verification
REQ-034 SHALL cover: reset, then alloc_req=11 -> alloc_preg0=32, alloc_preg1=33, alloc_ready=1; next cycle free_count=30.
REQ-035 SHALL cover: 16 cycles of alloc_req=11 -> free_count=0; then alloc_req=01 -> alloc_ready=0, spec_head unchanged.
REQ-036 SHALL cover: free_count=1, alloc_req=11 -> alloc_ready=0; alloc_req=10 -> alloc_ready=1 and alloc_preg1 = buf[spec_head].
REQ-037 SHALL cover: allocate 32,33,34; retire_valid=01 with old_preg0=5; flush same cycle -> next cycle free_count=32, alloc_preg0=33, and 5 becomes allocatable after 31 more.
REQ-038 SHALL cover: at empty, retire_valid=11 (old 7, 9) with alloc_req=01 the same cycle -> alloc_ready=0; next cycle alloc_req=11 -> grants 7, 9.
REQ-039 SHALL cover: after reset, retire_valid=01 -> overflow_err=1, tail unchanged; resetn=0 -> overflow_err=0.
